// File: rtl/cp_bus_hold_arbiter_if.sv
// Bus bundle between the CPU data port, the coprocessor DMA master and the
// external data memory, as seen by the hold/hold-ack arbiter.
interface cp_bus_hold_arbiter_if;
    // CPU data-memory port
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_busy;
    logic        cpu_stall;
    // Coprocessor DMA master
    logic        dma_hold;
    logic        dma_hold_ack;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wd;
    logic [31:0] dma_rd;
    // External data memory
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    // Grant monitoring
    logic        hold_timeout;
    logic [15:0] grant_cycles;

    // Arbiter side
    modport slave (
        input  cpu_we, cpu_addr, cpu_wd, cpu_busy,
        input  dma_hold, dma_we, dma_addr, dma_wd,
        input  mem_rd,
        output cpu_rd, cpu_stall, dma_hold_ack, dma_rd,
        output mem_we, mem_addr, mem_wd,
        output hold_timeout, grant_cycles
    );

    // Environment side (CPU, DMA and memory models)
    modport master (
        output cpu_we, cpu_addr, cpu_wd, cpu_busy,
        output dma_hold, dma_we, dma_addr, dma_wd,
        output mem_rd,
        input  cpu_rd, cpu_stall, dma_hold_ack, dma_rd,
        input  mem_we, mem_addr, mem_wd,
        input  hold_timeout, grant_cycles
    );
endinterface

// File: rtl/cp_bus_hold_arbiter.sv
// HOLD/HOLD_ACK arbiter: stalls the CPU on a DMA hold request, waits for the
// CPU access to drain, hands the memory bus to the DMA master, and returns it
// through a one-cycle turnaround. Measures grant length and flags long holds.
module cp_bus_hold_arbiter #(
    parameter int unsigned DRAIN_CYCLES = 2,        // 1..15
    parameter logic [15:0] TIMEOUT      = 16'd4096
) (
    input  logic                   clk,
    input  logic                   rst,
    cp_bus_hold_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] LP_DRAIN = 4'(DRAIN_CYCLES);

    state_t      r_state,        w_state_next;
    logic        r_owner_dma,    w_owner_dma_next;
    logic        r_ack,          w_ack_next;
    logic        r_stall,        w_stall_next;
    logic [3:0]  r_drain_cnt,    w_drain_cnt_next;
    logic [15:0] r_grant_cycles, w_grant_cycles_next;
    logic        r_timeout,      w_timeout_next;

    logic [3:0]  w_drain_inc;
    logic [15:0] w_grant_inc;
    logic        w_fence;

    assign w_drain_inc = r_drain_cnt + 4'd1;
    assign w_grant_inc = (r_grant_cycles == 16'hFFFF) ? r_grant_cycles
                                                      : r_grant_cycles + 16'd1;

    // State and control registers; reset hands the bus straight back to the CPU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_owner_dma    <= 1'b0;
            r_ack          <= 1'b0;
            r_stall        <= 1'b0;
            r_drain_cnt    <= 4'd0;
            r_grant_cycles <= 16'd0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_owner_dma    <= w_owner_dma_next;
            r_ack          <= w_ack_next;
            r_stall        <= w_stall_next;
            r_drain_cnt    <= w_drain_cnt_next;
            r_grant_cycles <= w_grant_cycles_next;
            r_timeout      <= w_timeout_next;
        end
    end

    // Next-state logic: control outputs are computed for the state being entered.
    always_comb begin
        w_state_next        = r_state;
        w_owner_dma_next    = r_owner_dma;
        w_ack_next          = r_ack;
        w_stall_next        = r_stall;
        w_drain_cnt_next    = r_drain_cnt;
        w_grant_cycles_next = r_grant_cycles;
        w_timeout_next      = r_timeout;

        case (r_state)
            S_IDLE: begin
                w_owner_dma_next = 1'b0;
                w_ack_next       = 1'b0;
                w_stall_next     = 1'b0;
                if (bus.dma_hold) begin
                    // New request: freeze the CPU and restart the measurements.
                    w_state_next        = S_DRAIN;
                    w_stall_next        = 1'b1;
                    w_drain_cnt_next    = 4'd0;
                    w_grant_cycles_next = 16'd0;
                    w_timeout_next      = 1'b0;
                end
            end

            S_DRAIN: begin
                if (!bus.dma_hold) begin
                    // Request withdrawn before the grant.
                    w_state_next     = S_IDLE;
                    w_stall_next     = 1'b0;
                    w_drain_cnt_next = 4'd0;
                end else if (bus.cpu_busy) begin
                    // Idle run must be consecutive.
                    w_drain_cnt_next = 4'd0;
                end else if (w_drain_inc == LP_DRAIN) begin
                    w_state_next     = S_GRANT;
                    w_owner_dma_next = 1'b1;
                    w_ack_next       = 1'b1;
                    w_drain_cnt_next = 4'd0;
                end else begin
                    w_drain_cnt_next = w_drain_inc;
                end
            end

            S_GRANT: begin
                w_grant_cycles_next = w_grant_inc;
                if (w_grant_inc == TIMEOUT) begin
                    w_timeout_next = 1'b1;   // sticky; the grant is not revoked
                end
                if (!bus.dma_hold) begin
                    w_state_next = S_RELEASE;
                    w_ack_next   = 1'b0;
                end
            end

            S_RELEASE: begin
                // Single turnaround cycle; a pending hold is picked up from IDLE.
                w_state_next     = S_IDLE;
                w_owner_dma_next = 1'b0;
                w_stall_next     = 1'b0;
            end

            default: begin
                w_state_next     = S_IDLE;
                w_owner_dma_next = 1'b0;
                w_ack_next       = 1'b0;
                w_stall_next     = 1'b0;
                w_drain_cnt_next = 4'd0;
            end
        endcase
    end

    // Memory writes are blocked while the bus is changing hands.
    assign w_fence = (r_state == S_DRAIN) || (r_state == S_RELEASE);

    assign bus.mem_addr     = r_owner_dma ? bus.dma_addr : bus.cpu_addr;
    assign bus.mem_wd       = r_owner_dma ? bus.dma_wd   : bus.cpu_wd;
    assign bus.mem_we       = w_fence ? 1'b0 : (r_owner_dma ? bus.dma_we : bus.cpu_we);
    assign bus.cpu_rd       = r_owner_dma ? 32'd0 : bus.mem_rd;
    assign bus.dma_rd       = r_owner_dma ? bus.mem_rd : 32'd0;

    assign bus.cpu_stall    = r_stall;
    assign bus.dma_hold_ack = r_ack;
    assign bus.hold_timeout = r_timeout;
    assign bus.grant_cycles = r_grant_cycles;

endmodule

// File: tb/tb_cp_bus_hold_arbiter.sv
// Testbench for cp_bus_hold_arbiter: directed scenarios followed by random
// hold/busy traffic, all checked against a cycle-level behavioural model.
module tb_cp_bus_hold_arbiter;

    localparam int          DRAIN = 2;
    localparam logic [15:0] TMO   = 16'd8;

    logic clk;
    logic rst;

    cp_bus_hold_arbiter_if bus();

    cp_bus_hold_arbiter #(
        .DRAIN_CYCLES (DRAIN),
        .TIMEOUT      (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference model: what the bus currently "is doing"
    bit m_waiting;     // request seen, waiting for the CPU to go quiet
    bit m_granted;     // DMA holds the bus
    bit m_turn;        // one-cycle handback
    int m_idle_run;    // consecutive quiet CPU cycles while waiting
    int m_len;         // grant length
    bit m_to;          // long-hold flag

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_waiting  = 0;
        m_granted  = 0;
        m_turn     = 0;
        m_idle_run = 0;
        m_len      = 0;
        m_to       = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit h;
        bit b;
        h = bus.dma_hold;
        b = bus.cpu_busy;
        if (m_turn) begin
            m_turn = 0;
        end else if (m_granted) begin
            if (m_len < 65535) m_len++;
            if (m_len == int'(TMO)) m_to = 1;
            if (!h) begin
                m_granted = 0;
                m_turn    = 1;
            end
        end else if (m_waiting) begin
            if (!h) begin
                m_waiting = 0;
            end else if (b) begin
                m_idle_run = 0;
            end else begin
                m_idle_run++;
                if (m_idle_run == DRAIN) begin
                    m_waiting = 0;
                    m_granted = 1;
                end
            end
        end else if (h) begin
            m_waiting  = 1;
            m_idle_run = 0;
            m_len      = 0;
            m_to       = 0;
        end
    endtask

    task automatic check_all(input string tag);
        bit own_dma;
        bit no_write;
        bit exp_we;
        own_dma  = m_granted | m_turn;
        no_write = m_waiting | m_turn;
        exp_we   = no_write ? 1'b0 : (own_dma ? bus.dma_we : bus.cpu_we);
        check({tag, ":stall"},   64'(bus.cpu_stall),    64'(m_waiting | m_granted | m_turn));
        check({tag, ":ack"},     64'(bus.dma_hold_ack), 64'(m_granted));
        check({tag, ":mem_we"},  64'(bus.mem_we),       64'(exp_we));
        check({tag, ":mem_addr"},64'(bus.mem_addr),     64'(own_dma ? bus.dma_addr : bus.cpu_addr));
        check({tag, ":mem_wd"},  64'(bus.mem_wd),       64'(own_dma ? bus.dma_wd : bus.cpu_wd));
        check({tag, ":cpu_rd"},  64'(bus.cpu_rd),       64'(own_dma ? 32'd0 : bus.mem_rd));
        check({tag, ":dma_rd"},  64'(bus.dma_rd),       64'(own_dma ? bus.mem_rd : 32'd0));
        check({tag, ":timeout"}, 64'(bus.hold_timeout), 64'(m_to));
        check({tag, ":gcycles"}, 64'(bus.grant_cycles), 64'(m_len));
    endtask

    task automatic drive(input bit h, input bit b,
                         input bit cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                         input bit dwe, input logic [31:0] daddr, input logic [31:0] dwd);
        bus.dma_hold = h;
        bus.cpu_busy = b;
        bus.cpu_we   = cwe;
        bus.cpu_addr = caddr;
        bus.cpu_wd   = cwd;
        bus.dma_we   = dwe;
        bus.dma_addr = daddr;
        bus.dma_wd   = dwd;
        bus.mem_rd   = $urandom;
        #1;
        check_all("comb");
    endtask

    task automatic drive_rnd(input bit h, input bit b);
        drive(h, b, 1'($urandom), $urandom, $urandom, 1'($urandom), $urandom, $urandom);
    endtask

    // One clock edge, then compare registered state.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        $display("[%0t] %s hold=%0b busy=%0b stall=%0b ack=%0b mem_we=%0b mem_addr=%08h gc=%0d to=%0b",
                 $time, tag, bus.dma_hold, bus.cpu_busy, bus.cpu_stall, bus.dma_hold_ack,
                 bus.mem_we, bus.mem_addr, bus.grant_cycles, bus.hold_timeout);
    endtask

    initial begin
        bit hold;
        bit busy;

        // Reset
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        check("reset_ack", 64'(bus.dma_hold_ack), 64'd0);
        check("reset_gc",  64'(bus.grant_cycles), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // CPU write with no hold
        drive(0, 0, 1, 32'h10, 32'h1234_5678, 1, 32'h55, 32'h66);
        check("cpuwr_we",   64'(bus.mem_we),   64'd1);
        check("cpuwr_addr", 64'(bus.mem_addr), 64'h10);
        check("cpuwr_wd",   64'(bus.mem_wd),   64'h1234_5678);
        tick("cpu_write");
        check("cpuwr_stall", 64'(bus.cpu_stall), 64'd0);

        // Hold with quiet CPU: stall after one edge, ack two edges after entry
        drive_rnd(1, 0);
        tick("hold_e1");
        check("hold_e1_stall", 64'(bus.cpu_stall),    64'd1);
        check("hold_e1_ack",   64'(bus.dma_hold_ack), 64'd0);
        drive_rnd(1, 0);
        tick("hold_e2");
        check("hold_e2_ack",   64'(bus.dma_hold_ack), 64'd0);
        drive_rnd(1, 0);
        tick("hold_e3");
        check("hold_e3_ack",   64'(bus.dma_hold_ack), 64'd1);

        // DMA write in the first granted cycle
        drive(1, 0, 1, 32'h20, 32'hDEAD_BEEF, 1, 32'h100, 32'hCAFE_0001);
        check("dmawr_we",   64'(bus.mem_we),   64'd1);
        check("dmawr_addr", 64'(bus.mem_addr), 64'h100);
        check("dmawr_wd",   64'(bus.mem_wd),   64'hCAFE_0001);
        check("dmawr_cpurd",64'(bus.cpu_rd),   64'd0);

        // Hold for 10 grant edges; long-hold flag after the 8th
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) drive_rnd(1, 0);
            tick("grant");
            check("grant_len", 64'(bus.grant_cycles), 64'(i));
            check("grant_to",  64'(bus.hold_timeout), 64'(i >= 8));
            check("grant_ack", 64'(bus.dma_hold_ack), 64'd1);
        end
        drive(0, 0, 1, 32'h30, 32'h1, 1, 32'h40, 32'h2);
        tick("release");
        check("rel_ack",   64'(bus.dma_hold_ack), 64'd0);
        check("rel_stall", 64'(bus.cpu_stall),    64'd1);
        check("rel_we",    64'(bus.mem_we),       64'd0);
        check("rel_gc",    64'(bus.grant_cycles), 64'd10);
        drive(0, 0, 1, 32'h30, 32'h1, 1, 32'h40, 32'h2);
        tick("after_rel");
        check("after_stall", 64'(bus.cpu_stall),    64'd0);
        check("after_gc",    64'(bus.grant_cycles), 64'd10);

        // Busy CPU during drain: ack two edges after busy falls
        drive(1, 1, 1, 32'h50, 32'h3, 0, 32'h0, 32'h0);
        tick("busy_entry");
        check("busy_to_clr", 64'(bus.hold_timeout), 64'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 32'h50, 32'h3, 0, 32'h0, 32'h0);
            check("busy_we", 64'(bus.mem_we), 64'd0);
            tick("busy_drain");
            check("busy_ack", 64'(bus.dma_hold_ack), 64'd0);
        end
        drive(1, 0, 1, 32'h50, 32'h3, 0, 32'h0, 32'h0);
        tick("busy_fall1");
        check("busy_f1_ack", 64'(bus.dma_hold_ack), 64'd0);
        drive(1, 0, 1, 32'h50, 32'h3, 0, 32'h0, 32'h0);
        tick("busy_fall2");
        check("busy_f2_ack", 64'(bus.dma_hold_ack), 64'd1);

        // Asynchronous reset in the middle of a grant
        drive(1, 0, 1, 32'hABC, 32'h7, 1, 32'h200, 32'h8);
        tick("pre_rst");
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_ack",   64'(bus.dma_hold_ack), 64'd0);
        check("arst_stall", 64'(bus.cpu_stall),    64'd0);
        check("arst_addr",  64'(bus.mem_addr),     64'hABC);
        check_all("arst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 1, 32'hABC, 32'h7, 1, 32'h200, 32'h8);
        tick("post_rst");
        check("prst_stall", 64'(bus.cpu_stall),    64'd1);
        check("prst_ack",   64'(bus.dma_hold_ack), 64'd0);

        // Random traffic
        hold = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) hold = ~hold;
            busy = ($urandom_range(0, 2) == 0);
            drive_rnd(hold, busy);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
